ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit; sits directly upstream of the decode stage.
- Holds the PC and issues one fetch request per instruction to the instruction memory port.
- Presents the returned instruction, pre-split into opcode/funct3/funct7, with a valid/ready handshake to decode.
- Waits for the execute/write-back stage to return the next PC before fetching again (one instruction in flight).

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, PC and instruction width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  fetch address, equal to pc.
- imem_resp_valid  input  1  instruction data returned, single-cycle pulse.
- imem_resp_data  input  XLEN  returned instruction word.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode accepts the instruction.
- inst  output  XLEN  registered instruction word.
- opcode  output  7  inst[6:0].
- funct3  output  3  inst[14:12].
- funct7  output  7  inst[31:25].
- pc  output  XLEN  address of the presented instruction.
- npc_valid  input  1  next PC from execute/write-back is valid.
- npc  input  XLEN  next PC value (pc+4 or branch/jump target).
- fetch_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC, inst=0, state=IDLE.
  - imem_req_valid=0, inst_valid=0, fetch_busy=0.
  - Any in-flight request or response is abandoned; a response arriving after reset release with no request outstanding is ignored.
- State machine, one-hot or binary, 5 states:
  - IDLE: exits to REQ on the first clock after reset release; no other entry.
  - REQ:
    - imem_req_valid=1, imem_req_addr=pc.
    - On imem_req_valid&&imem_req_ready -> WAIT_RESP.
    - imem_req_valid stays asserted and addr stays stable until accepted.
  - WAIT_RESP:
    - On imem_resp_valid: latch imem_resp_data into inst -> HOLD.
    - A response in the same cycle as request acceptance is not possible; the memory returns at least 1 cycle later.
  - HOLD:
    - inst_valid=1; inst/opcode/funct3/funct7/pc stable while inst_valid&&!inst_ready.
    - On inst_valid&&inst_ready -> WAIT_NPC; inst_valid drops the next cycle.
  - WAIT_NPC:
    - On npc_valid: pc<=npc -> REQ.
    - If npc_valid and inst_ready were both high in the previous HOLD cycle, npc is ignored; npc is sampled only in WAIT_NPC.
- npc_valid in any state other than WAIT_NPC is ignored.
- imem_resp_valid outside WAIT_RESP is ignored; inst does not change.
- Latency: reset release -> first imem_req_valid = 1 cycle. Response -> inst_valid = 1 cycle. npc_valid -> next imem_req_valid = 1 cycle.
- No arithmetic in this block; PC increment is done downstream and supplied via npc. PC wraps naturally at 2^XLEN because npc is taken as-is.
- opcode/funct3/funct7 are pure slices of the registered inst, so they are 0 after reset.

Optional Feature:
- Macro IFU_MISALIGN_CHECK_EN.
- With macro defined:
  - Extra output misalign_fault (1 bit, reset 0).
  - In WAIT_NPC, if npc_valid&&npc[1:0]!=2'b00: pc is not updated, misalign_fault<=1, state -> IDLE-halted. Halted means no further requests; only reset clears it.
- Without macro: port absent; npc is loaded unconditionally, low bits included.

Test Plan:
- Reset then release; memory ready=1, response 2 cycles after the request with data 32'h00000413 -> imem_req_addr=32'h8000_0000; inst_valid rises 1 cycle after the response; opcode=7'h13, funct3=0, funct7=0, pc=32'h8000_0000.
- Decode holds inst_ready=0 for 5 cycles in HOLD -> inst, pc and opcode are unchanged, no new imem request; inst_ready=1 -> inst_valid low the next cycle.
- In WAIT_NPC apply npc=32'h8000_0004 with npc_valid -> next cycle imem_req_valid=1, addr=32'h8000_0004; a jump npc=32'h8000_0100 likewise yields addr=32'h8000_0100.
- imem_req_ready held 0 for 3 cycles -> imem_req_valid and addr remain stable for all 3 cycles; a spurious resp_valid during REQ is ignored.
- Assert rst_n=0 in WAIT_RESP, then deliver the response after release -> pc=RESET_PC, inst=0, inst_valid=0; the stale response is ignored and a fresh request goes to 32'h8000_0000.
- IFU_MISALIGN_CHECK_EN defined, npc=32'h8000_0006 -> misalign_fault=1, pc stays at the old value, no request issued for 10 cycles.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, issues one memory request per instruction and
// presents the returned word to decode. Optional misaligned-npc trap: IFU_MISALIGN_CHECK_EN.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] pc,
  input  logic            npc_valid,
  input  logic [XLEN-1:0] npc,
  output logic            fetch_busy
`ifdef IFU_MISALIGN_CHECK_EN
  , output logic          misalign_fault
`endif
);

  // state     | meaning
  // IDLE      | after reset, or halted on a misaligned npc
  // REQ       | request to imem pending acceptance
  // WAIT_RESP | request accepted, waiting for instruction data
  // HOLD      | instruction presented to decode
  // WAIT_NPC  | waiting for execute/write-back to supply the next pc
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_RESP = 3'd2,
    HOLD      = 3'd3,
    WAIT_NPC  = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   npc_bad;
  logic   halted;

`ifdef IFU_MISALIGN_CHECK_EN
  assign npc_bad = (npc[1:0] != 2'b00);
  assign halted  = misalign_fault;
`else
  assign npc_bad = 1'b0;
  assign halted  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!halted)         state_nxt = REQ;
      REQ:       if (imem_req_ready)  state_nxt = WAIT_RESP;
      WAIT_RESP: if (imem_resp_valid) state_nxt = HOLD;
      HOLD:      if (inst_ready)      state_nxt = WAIT_NPC;
      WAIT_NPC:  if (npc_valid)       state_nxt = npc_bad ? IDLE : REQ;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    fetch_busy     = 1'b1;
    case (state)
      IDLE:    fetch_busy     = 1'b0;
      REQ:     imem_req_valid = 1'b1;
      HOLD:    inst_valid     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= RESET_PC[XLEN-1:0];
      inst <= '0;
    end else begin
      if (state == WAIT_RESP && imem_resp_valid)
        inst <= imem_resp_data;
      if (state == WAIT_NPC && npc_valid && !npc_bad)
        pc <= npc;
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  // Sticky until reset; keeps the FSM parked in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misalign_fault <= 1'b0;
    else if (state == WAIT_NPC && npc_valid && npc_bad)
      misalign_fault <= 1'b1;
  end
`endif

  assign imem_req_addr = pc;
  assign opcode        = inst[6:0];
  assign funct3        = inst[14:12];
  assign funct7        = inst[31:25];

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch; covers the IFU_MISALIGN_CHECK_EN build
// when that macro is defined, and the unconditional npc load otherwise.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pc;
  logic        npc_valid;
  logic [31:0] npc;
  logic        fetch_busy;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        misalign_fault;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  ifu_fetch #(.RESET_PC(RST_PC), .XLEN(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .opcode          (opcode),
    .funct3          (funct3),
    .funct7          (funct7),
    .pc              (pc),
    .npc_valid       (npc_valid),
    .npc             (npc),
    .fetch_busy      (fetch_busy)
`ifdef IFU_MISALIGN_CHECK_EN
    , .misalign_fault(misalign_fault)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    inst_ready = 1'b0; npc_valid = 1'b0; npc = '0;
    repeat (3) step();

    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, 0);
    chk("rst_opcode", opcode, 0);
`ifdef IFU_MISALIGN_CHECK_EN
    chk("rst_misalign", misalign_fault, 0);
`endif

    // First fetch: request one cycle after release, response two cycles after it
    rst_n = 1'b1;
    step();
    chk("f1_req_valid", imem_req_valid, 1);
    chk("f1_req_addr", imem_req_addr, 32'h8000_0000);
    chk("f1_busy", fetch_busy, 1);
    step();
    chk("f1_req_dropped", imem_req_valid, 0);
    step();
    chk("f1_no_inst_yet", inst_valid, 0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0413;
    step();
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    chk("f1_inst_valid", inst_valid, 1);
    chk("f1_inst", inst, 32'h0000_0413);
    chk("f1_opcode", opcode, 7'h13);
    chk("f1_funct3", funct3, 0);
    chk("f1_funct7", funct7, 0);
    chk("f1_pc", pc, 32'h8000_0000);

    // Decode stalls 5 cycles; stray npc and response must be ignored meanwhile
    npc_valid = 1'b1; npc = 32'h1234_5678;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_inst_valid", inst_valid, 1);
      chk("hold_inst", inst, 32'h0000_0413);
      chk("hold_opcode", opcode, 7'h13);
      chk("hold_pc", pc, 32'h8000_0000);
      chk("hold_no_req", imem_req_valid, 0);
    end
    imem_resp_valid = 1'b0;
    inst_ready = 1'b1;
    step();
    npc_valid = 1'b0; inst_ready = 1'b0;
    chk("acc_inst_valid_low", inst_valid, 0);
    chk("acc_pc_unchanged", pc, 32'h8000_0000);
    step();
    chk("wnpc_no_req", imem_req_valid, 0);
    chk("wnpc_busy", fetch_busy, 1);

    // Sequential next pc
    npc_valid = 1'b1; npc = 32'h8000_0004;
    step();
    npc_valid = 1'b0; npc = '0;
    chk("seq_req_valid", imem_req_valid, 1);
    chk("seq_req_addr", imem_req_addr, 32'h8000_0004);

    // Memory backpressure for 3 cycles, with a spurious response mid-way
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      imem_resp_valid = (i == 1); imem_resp_data = 32'hFFFF_FFFF;
      step();
      chk("stall_req_valid", imem_req_valid, 1);
      chk("stall_req_addr", imem_req_addr, 32'h8000_0004);
    end
    imem_resp_valid = 1'b0;
    chk("stall_inst_kept", inst, 32'h0000_0413);
    chk("stall_no_inst_valid", inst_valid, 0);
    imem_req_ready = 1'b1;
    step();
    chk("f2_req_dropped", imem_req_valid, 0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h40B5_5533;
    step();
    imem_resp_valid = 1'b0;
    chk("f2_inst_valid", inst_valid, 1);
    chk("f2_opcode", opcode, 7'h33);
    chk("f2_funct3", funct3, 3'h5);
    chk("f2_funct7", funct7, 7'h20);
    chk("f2_pc", pc, 32'h8000_0004);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("f2_inst_valid_low", inst_valid, 0);

    // Jump target
    npc_valid = 1'b1; npc = 32'h8000_0100;
    step();
    npc_valid = 1'b0;
    chk("jmp_req_valid", imem_req_valid, 1);
    chk("jmp_req_addr", imem_req_addr, 32'h8000_0100);
    step();
    chk("jmp_wait_resp", imem_req_valid, 0);

    // Async reset while waiting for the response; the late response is stale
    rst_n = 1'b0;
    #1;
    chk("ar_pc", pc, RST_PC);
    chk("ar_inst", inst, 0);
    chk("ar_inst_valid", inst_valid, 0);
    chk("ar_req_valid", imem_req_valid, 0);
    chk("ar_busy", fetch_busy, 0);
    rst_n = 1'b1;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hFFFF_FFFF;
    step();
    imem_resp_valid = 1'b0;
    chk("ar_stale_inst", inst, 0);
    chk("ar_req_valid_again", imem_req_valid, 1);
    chk("ar_req_addr", imem_req_addr, 32'h8000_0000);

    // Fetch once more, then supply a misaligned npc
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
    step();
    imem_resp_valid = 1'b0;
    chk("f3_inst_valid", inst_valid, 1);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    npc_valid = 1'b1; npc = 32'h8000_0006;
    step();
    npc_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis_fault", misalign_fault, 1);
    chk("mis_pc_kept", pc, 32'h8000_0000);
    chk("mis_busy", fetch_busy, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mis_no_req", imem_req_valid, 0);
      chk("mis_fault_sticky", misalign_fault, 1);
    end
`else
    chk("noalign_req_valid", imem_req_valid, 1);
    chk("noalign_req_addr", imem_req_addr, 32'h8000_0006);
    chk("noalign_pc", pc, 32'h8000_0006);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
